// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: matrix rows/columns plus the decoded key outputs.
// The master side is the scanner; the slave side is the keypad matrix and its consumer.
interface keypad_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with one shared debounce counter.
// Emits a one-cycle strobe and a row*4+col code per debounced press.
module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES = 15,
  parameter int unsigned DB_CYCLES     = 999999
) (
  input  logic     clk,
  input  logic     rst_n,
  keypad_if.master kp
);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam logic [26:0] DB_LAST     = 27'(DB_CYCLES);

  logic [3:0]  r_sync1;
  logic [3:0]  r_rs;
  state_t      r_state;
  logic [1:0]  r_col;
  logic [7:0]  r_settle_cnt;
  logic [26:0] r_db_cnt;
  logic [1:0]  r_cap_row;
  logic [3:0]  r_col_out;
  logic [3:0]  r_key_code;
  logic        r_key_valid;
  logic        r_key_held;

  state_t      w_state_nxt;
  logic [1:0]  w_col_nxt;
  logic [7:0]  w_settle_nxt;
  logic [26:0] w_db_nxt;
  logic [1:0]  w_cap_nxt;
  logic [3:0]  w_code_nxt;
  logic        w_valid_nxt;
  logic        w_held_nxt;
  logic        w_idle;
  logic [1:0]  w_low_row;

  function automatic logic [1:0] f_low_row(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else if (!v[3]) idx = 2'd3;
    return idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_rs    <= '1;
    end else begin
      r_sync1 <= kp.row_in;
      r_rs    <= r_sync1;
    end
  end

  assign w_idle    = (r_rs == 4'hF);
  assign w_low_row = f_low_row(r_rs);

  // A row-index change (not just any bit change) restarts debounce, so a second
  // key in the same column below the captured one does not disturb it.
  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col;
    w_settle_nxt = r_settle_cnt;
    w_db_nxt     = r_db_cnt;
    w_cap_nxt    = r_cap_row;
    w_code_nxt   = r_key_code;
    w_valid_nxt  = 1'b0;
    w_held_nxt   = r_key_held;
    case (r_state)
      ST_SCAN: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          if (w_idle) begin
            w_col_nxt    = r_col + 2'd1;
            w_settle_nxt = '0;
          end else begin
            w_cap_nxt   = w_low_row;
            w_db_nxt    = '0;
            w_state_nxt = ST_DEBOUNCE;
          end
        end else begin
          w_settle_nxt = r_settle_cnt + 8'd1;
        end
      end
      ST_DEBOUNCE: begin
        if (w_idle) begin
          w_state_nxt  = ST_SCAN;
          w_col_nxt    = r_col + 2'd1;
          w_settle_nxt = '0;
        end else if (w_low_row != r_cap_row) begin
          w_cap_nxt = w_low_row;
          w_db_nxt  = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nxt = ST_HELD;
          w_code_nxt  = {r_cap_row, r_col};
          w_valid_nxt = 1'b1;
          w_held_nxt  = 1'b1;
        end else begin
          w_db_nxt = r_db_cnt + 27'd1;
        end
      end
      ST_HELD: begin
        if (w_idle) begin
          w_db_nxt    = '0;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!w_idle) begin
          w_db_nxt    = '0;
          w_state_nxt = ST_HELD;
        end else if (r_db_cnt == DB_LAST) begin
          w_held_nxt   = 1'b0;
          w_state_nxt  = ST_SCAN;
          w_col_nxt    = r_col + 2'd1;
          w_settle_nxt = '0;
        end else begin
          w_db_nxt = r_db_cnt + 27'd1;
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SCAN;
      r_col        <= '0;
      r_settle_cnt <= '0;
      r_db_cnt     <= '0;
      r_cap_row    <= '0;
      r_col_out    <= 4'b1110;
      r_key_code   <= '0;
      r_key_valid  <= 1'b0;
      r_key_held   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_col        <= w_col_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_db_cnt     <= w_db_nxt;
      r_cap_row    <= w_cap_nxt;
      r_col_out    <= ~(4'b0001 << w_col_nxt);
      r_key_code   <= w_code_nxt;
      r_key_valid  <= w_valid_nxt;
      r_key_held   <= w_held_nxt;
    end
  end

  assign kp.col_out   = r_col_out;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;
  assign kp.key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: matrix model, code scoreboard, latency checks.
// Runs with SETTLE_CYCLES=4, DB_CYCLES=20.
module tb_keypad_scanner;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned DB     = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;
  int          n_total = 0;
  int          n_bad = 0;
  int          n_strobe = 0;
  int          n_pushed = 0;
  logic [3:0]  exp_q[$];

  keypad_if kif();

  keypad_scanner #(
    .SETTLE_CYCLES(SETTLE),
    .DB_CYCLES(DB)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .kp(kif)
  );

  always #5 clk = ~clk;

  // Pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    kif.row_in = '1;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.col_out[c]) kif.row_in[r] = 1'b0;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] code);
    exp_q.push_back(code);
    n_pushed++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_strobe(input int max_c, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (kif.key_valid !== 1'b1 && n < max_c);
    if (kif.key_valid !== 1'b1) chk_eq("strobe_timeout", 32'(kif.key_valid), 1);
  endtask

  task automatic wait_held_low(input int max_c, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (kif.key_held !== 1'b0 && n < max_c);
    if (kif.key_held !== 1'b0) chk_eq("held_timeout", 32'(kif.key_held), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (kif.key_valid === 1'b1) begin
      n_strobe++;
      chk_eq("strobe_count", n_strobe, n_pushed);
      if (exp_q.size() != 0) chk_eq("strobe_code", kif.key_code, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         s0;
    logic [3:0] exp_col;

    // Reset values and idle sweep: 5 cycles per column.
    rst_n = 1'b0;
    repeat (3) tick();
    chk_eq("rst_col_out", kif.col_out, 4'b1110);
    chk_eq("rst_code", kif.key_code, 0);
    chk_eq("rst_valid", 32'(kif.key_valid), 0);
    chk_eq("rst_held", 32'(kif.key_held), 0);
    rst_n = 1'b1;
    for (int unsigned i = 1; i <= 40; i++) begin
      tick();
      exp_col = ~(4'b0001 << ((i / 5) % 4));
      chk_eq("idle_col", kif.col_out, exp_col);
      chk_eq("idle_flags", {kif.key_valid, kif.key_held}, 2'b00);
    end

    // Clean press row2/col1: col1 sampled at edge 10, strobe DB+1 later.
    keys[9] = 1'b1;
    push_exp(4'd9);
    do_reset();
    wait_strobe(100, n);
    chk_eq("press_latency", n, 31);
    chk_eq("press_held", 32'(kif.key_held), 1);
    repeat (200) tick();
    chk_eq("hold_held", 32'(kif.key_held), 1);
    chk_eq("hold_code", kif.key_code, 9);
    keys = '0;
    wait_held_low(100, n);
    chk_eq("release_latency", n, 24);
    chk_eq("resume_col", kif.col_out, 4'b1011);

    // Glitch row1/col0 for 12 cycles: debounce abandoned, scan moves to col1.
    keys[4] = 1'b1;
    do_reset();
    s0 = n_strobe;
    repeat (12) tick();
    keys[4] = 1'b0;
    tick();
    tick();
    chk_eq("glitch_col_hold", kif.col_out, 4'b1110);
    tick();
    chk_eq("glitch_col_next", kif.col_out, 4'b1101);
    repeat (60) tick();
    chk_eq("glitch_no_strobe", n_strobe - s0, 0);
    chk_eq("glitch_held", 32'(kif.key_held), 0);

    // Bounce row0/col3: 8 toggles of 8 cycles, then steady press.
    keys = '0;
    do_reset();
    s0 = n_strobe;
    push_exp(4'd3);
    for (int unsigned p = 0; p < 8; p++) begin
      keys[3] = (p % 2 == 0);
      repeat (8) tick();
    end
    keys[3] = 1'b1;
    wait_strobe(60, n);
    chk_eq("bounce_latency_window", 32'(n >= 23 && n <= 50), 1);
    repeat (100) tick();
    chk_eq("bounce_one_strobe", n_strobe - s0, 1);
    keys = '0;
    wait_held_low(100, n);

    // Multi-key rows 1 and 3 in col2: row 1 wins.
    keys[6]  = 1'b1;
    keys[14] = 1'b1;
    push_exp(4'd6);
    do_reset();
    wait_strobe(100, n);
    chk_eq("multi_latency", n, 36);

    // Reset while held: async clear, then full re-detection of the same key.
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk_eq("async_held", 32'(kif.key_held), 0);
    chk_eq("async_valid", 32'(kif.key_valid), 0);
    chk_eq("async_code", kif.key_code, 0);
    chk_eq("async_col_out", kif.col_out, 4'b1110);
    repeat (3) tick();
    rst_n = 1'b1;
    push_exp(4'd6);
    wait_strobe(100, n);
    chk_eq("rst_redetect_latency", n, 36);

    repeat (5) tick();
    s0 = n_strobe;
    keys[6] = 1'b0;
    repeat (60) tick();
    chk_eq("multi_partial_held", 32'(kif.key_held), 1);
    chk_eq("multi_no_second", n_strobe - s0, 0);
    chk_eq("multi_code_kept", kif.key_code, 6);
    keys = '0;
    wait_held_low(100, n);
    chk_eq("multi_release_latency", n, 24);

    chk_eq("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad for the calculator front end. It sequences column drive and row sampling, and shares one debounce counter across all 16 keys. It emits a 4-bit key code with a single-cycle valid strobe per debounced press. It replaces per-key debounce instances and feeds the calculator input decoder directly.

## Interface
- SETTLE_CYCLES, default 15: dwell cycles after a column change before rows are sampled; legal range 3 to 255.
- DB_CYCLES, default 999999: consecutive stable cycles required to accept a press or a release; legal range 1 to 2^27-1.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- row_in  input  4  raw keypad rows, active-low (pulled up); asynchronous to clk.
- col_out  output  4  column drive, active-low one-hot (driven column 0, others 1).
- key_code  output  4  code of the last accepted key, row*4+col.
- key_valid  output  1  one-cycle strobe on each accepted press.
- key_held  output  1  high from press acceptance until release acceptance.

## Operation
- row_in passes through a 2-FF synchronizer; the synchronized vector is rs.
- Internal registers:
  - col: 2-bit column index.
  - settle_cnt: 8 bits.
  - db_cnt: 27 bits, saturating at DB_CYCLES.
  - cap_row: 2 bits, captured row index.
- col_out is always ~(1<<col) and is registered.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - settle_cnt counts 0..SETTLE_CYCLES.
  - When settle_cnt==SETTLE_CYCLES, sample rs.
  - rs==4'hF: col<=col+1 (wraps 3->0), settle_cnt<=0.
  - Otherwise: cap_row<=lowest index with rs[i]==0, db_cnt<=0, go to DEBOUNCE, col unchanged.
- DEBOUNCE (column stays driven):
  - rs==4'hF: go to SCAN with col<=col+1 and settle_cnt<=0.
  - rs low bits differ from the captured row: recapture the lowest low row and set db_cnt<=0.
  - rs unchanged: db_cnt<=db_cnt+1.
  - db_cnt==DB_CYCLES: go to HELD; key_code<={cap_row,col}; key_valid<=1.
- HELD:
  - key_valid deasserts after one cycle; key_held=1.
  - rs==4'hF: db_cnt<=0, go to RELEASE.
- RELEASE:
  - rs==4'hF: db_cnt increments.
  - Any low bit in rs: db_cnt<=0, go back to HELD; no new strobe.
  - db_cnt==DB_CYCLES: key_held<=0; go to SCAN with col<=col+1 and settle_cnt<=0.
- Multiple keys in the driven column: the lowest row index wins.
- Keys in other columns are invisible while one key is being debounced or held.
- key_code holds its last value until the next accepted press.

## Timing
- Reset (async assert, sync release) values:
  - state SCAN, col 0, col_out 4'b1110.
  - settle_cnt 0, db_cnt 0.
  - key_code 0, key_valid 0, key_held 0.
- Column dwell in SCAN is SETTLE_CYCLES+1 cycles; a full idle sweep takes 4*(SETTLE_CYCLES+1) cycles.
- Input-to-sample latency is 2 synchronizer cycles; SETTLE_CYCLES>=3 guarantees the sampled rs reflects the current column.
- Press acceptance: key_valid rises DB_CYCLES+1 cycles after DEBOUNCE entry with no rs change.
- Release acceptance: key_held falls DB_CYCLES+1 cycles after RELEASE entry with rs stable high.
- key_valid is exactly one cycle wide; there is never more than one strobe per HELD entry from DEBOUNCE.
- db_cnt never exceeds DB_CYCLES.
- Reset asserted mid-operation clears all state immediately. If a key is still pressed after reset, it is re-detected from SCAN column 0 and requires full debounce.

## Test plan
All scenarios use SETTLE_CYCLES=4, DB_CYCLES=20.
- Idle sweep: rows 4'hF after reset.
  - col_out goes 1110→1101→1011→0111→1110, 5 cycles each.
  - key_valid stays 0 and key_held stays 0.
- Clean press: row 2 pulled low only while col 1 is driven, held 200 cycles, then released.
  - One key_valid pulse with key_code=9 (4'b1001).
  - key_held falls 21 cycles after the synchronized release.
  - Scanning resumes at col 2.
- Bounce: row 0 col 3 toggles every 8 cycles for 64 cycles, then stays low.
  - Exactly one strobe, with key_code=3.
  - The strobe comes 21 cycles after the last synchronized edge.
- Glitch: row 1 col 0 low for 12 cycles.
  - No strobe, key_held stays 0.
  - Scanning continues at col 1.
- Multi-key: rows 1 and 3 low in col 2.
  - key_code=6 (row 1 wins).
  - Releasing only row 1 keeps key_held=1 and produces no second strobe.
- Reset mid-HELD: assert rst_n low for 3 cycles while key_held=1.
  - Outputs return to reset values asynchronously.
  - With the key still pressed, one new strobe with the same code follows after re-detection plus 21 cycles.
